// File: rtl/pcpi_approx_multiplier.sv
// PCPI approximate multiplier: truncates the low APPROX_BITS of both operands, then does a shift-add multiply.
// Defining APPROX_MUL_HIGH_EN adds APPROXMULHU (funct3 011), which returns the high word of the product.
module pcpi_approx_multiplier #(
    parameter int unsigned APPROX_BITS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

`ifdef APPROX_MUL_HIGH_EN
    localparam int unsigned AccW = 64;
`else
    localparam int unsigned AccW = 32;
`endif

    localparam logic [31:0] Mask = 32'hFFFF_FFFF << APPROX_BITS;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [AccW-1:0]   acc_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [4:0]        cnt_q;
    logic              op_q;
    logic              insn_match;
    logic              unused_insn;

    always_comb begin
        insn_match = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'b0000001);
`ifdef APPROX_MUL_HIGH_EN
        insn_match = insn_match &&
                     ((pcpi_insn[14:12] == 3'b001) || (pcpi_insn[14:12] == 3'b011));
`else
        insn_match = insn_match && (pcpi_insn[14:12] == 3'b001);
`endif
    end

    // Register fields are irrelevant to this co-processor.
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pcpi_valid && insn_match) begin
                        acc_q   <= '0;
                        a_q     <= pcpi_rs1 & Mask;
                        b_q     <= pcpi_rs2 & Mask;
                        cnt_q   <= 5'(APPROX_BITS);
                        op_q    <= pcpi_insn[13];
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // Core withdrew the instruction: abandon without a ready pulse.
                    if (!pcpi_valid) begin
                        state_q <= StIdle;
                    end else begin
                        if (b_q[cnt_q]) begin
                            acc_q <= acc_q + (AccW'(a_q) << cnt_q);
                        end
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pcpi_wait  = (state_q == StRun);
    assign pcpi_ready = (state_q == StDone);
    assign pcpi_wr    = pcpi_ready;

    always_comb begin
        pcpi_rd = '0;
        if (pcpi_ready) begin
`ifdef APPROX_MUL_HIGH_EN
            pcpi_rd = op_q ? acc_q[63:32] : acc_q[31:0];
`else
            pcpi_rd = acc_q[31:0];
`endif
        end
    end

`ifndef APPROX_MUL_HIGH_EN
    logic unused_op;
    assign unused_op = op_q;
`endif

endmodule

// File: tb/tb_pcpi_approx_multiplier.sv
// Directed bench for pcpi_approx_multiplier with the default APPROX_BITS of 8.
module tb_pcpi_approx_multiplier;

    localparam int Latency = 24;

    localparam logic [31:0] InsnMul     = 32'h02B5_150B;
    localparam logic [31:0] InsnMulHu   = 32'h02B5_350B;
    localparam logic [31:0] InsnExact   = 32'h02B5_050B;
    localparam logic [31:0] InsnRvMul   = 32'h02B5_0533;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = '0;
    logic [31:0] pcpi_rs1 = '0;
    logic [31:0] pcpi_rs2 = '0;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int vectors = 0;
    int miscompares = 0;

    pcpi_approx_multiplier dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and follow it to its ready pulse.
    task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        @(posedge clk); #1;
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        @(posedge clk); #1;
        check({tag, " wait after accept"}, 32'(pcpi_wait), 32'd1);
        n = 0;
        while (!pcpi_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(Latency));
        check({tag, " rd"}, pcpi_rd, exp);
        check({tag, " wr"}, 32'(pcpi_wr), 32'd1);
        check({tag, " wait in done"}, 32'(pcpi_wait), 32'd0);
        pcpi_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready one cycle"}, 32'(pcpi_ready), 32'd0);
        check({tag, " rd cleared"}, pcpi_rd, 32'd0);
    endtask

    // Hold a non-matching instruction and confirm the block never reacts.
    task automatic idle_op(input string tag, input logic [31:0] insn);
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1;
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = 32'hFFFF_FFFF;
        pcpi_rs2   = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (pcpi_wait || pcpi_ready || pcpi_wr || (pcpi_rd != 32'd0)) seen = 1'b1;
        end
        pcpi_valid = 1'b0;
        check({tag, " stays idle"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic seen;
        #2;
        check("reset wait", 32'(pcpi_wait), 32'd0);
        check("reset ready", 32'(pcpi_ready), 32'd0);
        check("reset rd", pcpi_rd, 32'd0);
        #20;
        resetn = 1'b1;

        run_op("basic", InsnMul, 32'h0000_1234, 32'h0000_0100, 32'h0012_0000);
        run_op("truncate", InsnMul, 32'd5, 32'd7, 32'h0000_0000);
        run_op("max lo", InsnMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000);
`ifdef APPROX_MUL_HIGH_EN
        run_op("max hi", InsnMulHu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FE00);
`else
        idle_op("mulhu off", InsnMulHu);
`endif
        idle_op("rv mul", InsnRvMul);
        idle_op("exact f3", InsnExact);

        // Abort: drop valid after 10 RUN edges.
        @(posedge clk); #1;
        pcpi_valid = 1'b1;
        pcpi_insn  = InsnMul;
        pcpi_rs1   = 32'h0000_1234;
        pcpi_rs2   = 32'h0000_0100;
        repeat (11) @(posedge clk);
        #1;
        check("abort still running", 32'(pcpi_wait), 32'd1);
        pcpi_valid = 1'b0;
        @(posedge clk); #1;
        check("abort to idle", 32'(pcpi_wait), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (pcpi_ready || pcpi_wait) seen = 1'b1;
        end
        check("abort no ready", 32'(seen), 32'd0);
        run_op("recover", InsnMul, 32'h0001_0000, 32'h0000_0300, 32'h0300_0000);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        pcpi_valid = 1'b1;
        pcpi_insn  = InsnMul;
        pcpi_rs1   = 32'hFFFF_FFFF;
        pcpi_rs2   = 32'hFFFF_FFFF;
        repeat (6) @(posedge clk);
        #2;
        check("pre-reset wait", 32'(pcpi_wait), 32'd1);
        resetn = 1'b0;
        #1;
        check("async reset wait", 32'(pcpi_wait), 32'd0);
        check("async reset ready", 32'(pcpi_ready), 32'd0);
        check("async reset wr", 32'(pcpi_wr), 32'd0);
        check("async reset rd", pcpi_rd, 32'd0);
        pcpi_valid = 1'b0;
        @(posedge clk); #3;
        resetn = 1'b1;
        run_op("post reset", InsnMul, 32'h0000_1234, 32'h0000_0100, 32'h0012_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
